// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-side connection between a data producer and uart_tx.
//
// Signals
//   P_Data      producer -> uart  word to transmit
//   Data_Valid  producer -> uart  one-cycle request strobe
//   Parity_En   producer -> uart  1 = append a parity bit
//   Parity_Typ  producer -> uart  0 = even, 1 = odd parity
//   TX_out      uart -> line      serial output, idle high
//   Busy        uart -> producer  high while a frame is on the line
//
// Modports
//   master  the data producer
//   slave   the transmitter
interface uart_tx_if #(
  parameter int DATA_WD = 8
);
  logic [DATA_WD-1:0] P_Data;
  logic               Data_Valid;
  logic               Parity_En;
  logic               Parity_Typ;
  logic               TX_out;
  logic               Busy;

  modport master (
    output P_Data, Data_Valid, Parity_En, Parity_Typ,
    input  TX_out, Busy
  );

  modport slave (
    input  P_Data, Data_Valid, Parity_En, Parity_Typ,
    output TX_out, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one bit per clock (Clk is the baud clock).
// Frame: start(0), DATA_WD data bits LSB first, optional parity, stop(1).
//
// Ports
//   Clk  baud clock, rising-edge logic
//   Rst  asynchronous active-low reset; aborts any frame in flight
//   bus  uart_tx_if.slave: P_Data/Data_Valid/Parity_En/Parity_Typ in,
//        TX_out/Busy out (both registered)
module uart_tx #(
  parameter int DATA_WD = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  uart_tx_if.slave   bus
);

  localparam int CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
  localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(DATA_WD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_reg, state_next;
  logic [DATA_WD-1:0]  shift_reg;
  logic [CNT_WD-1:0]   cnt_reg;
  logic                par_en_reg;
  logic                par_bit_reg;
  logic                tx_reg, tx_next;
  logic                busy_reg, busy_next;

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; Data_Valid only matters in IDLE, so requests never queue
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.Data_Valid) state_next = START;
      START:   state_next = DATA;
      DATA:    if (cnt_reg == LAST_BIT) state_next = par_en_reg ? PARITY : STOP;
      PARITY:  state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic is decoded from the next state and registered below, so the
  // line level for a state appears in the same cycle the FSM enters it.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      PARITY:  tx_next = par_bit_reg;
      default: tx_next = 1'b1;
    endcase
  end

  // Serializer, bit counter and parity capture. Everything the frame needs is
  // latched at acceptance so later input changes cannot disturb it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shift_reg   <= '0;
      cnt_reg     <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.Data_Valid) begin
        shift_reg   <= bus.P_Data;
        cnt_reg     <= '0;
        par_en_reg  <= bus.Parity_En;
        // even: XOR-reduce; odd: XNOR-reduce
        par_bit_reg <= (^bus.P_Data) ^ bus.Parity_Typ;
      end else begin
        // Shift on the same edge that registers shift_reg[0] onto the line
        if (state_next == DATA)
          shift_reg <= shift_reg >> 1;
        if (state_reg == DATA)
          cnt_reg <= (cnt_reg == LAST_BIT) ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
    end else begin
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
    end
  end

  assign bus.TX_out = tx_reg;
  assign bus.Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Each accepted frame pushes its
// expected (TX_out, Busy) samples to a queue; the bench pops one entry per
// falling edge and compares it against the line.
module tb_uart_tx;

  localparam int DATA_WD = 8;

  logic Clk;
  logic Rst;

  uart_tx_if #(.DATA_WD(DATA_WD)) bus_if ();

  uart_tx #(.DATA_WD(DATA_WD)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // {tx, busy} per sampled cycle
  logic [1:0] exp_q[$];

  function automatic logic odd_ones(input logic [DATA_WD-1:0] d);
    int n = 0;
    for (int i = 0; i < DATA_WD; i++) if (d[i]) n++;
    return (n % 2) == 1;
  endfunction

  // Expected line: start, data LSB first, optional parity, stop, two idle cycles
  task automatic push_frame(input logic [DATA_WD-1:0] d, input logic pen, input logic ptyp);
    logic par;
    exp_q.push_back(2'b01);
    for (int i = 0; i < DATA_WD; i++) exp_q.push_back({d[i], 1'b1});
    if (pen) begin
      // even parity: bit makes total ones even; odd parity: total ones odd
      par = ptyp ? ~odd_ones(d) : odd_ones(d);
      exp_q.push_back({par, 1'b1});
    end
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
  endtask

  task automatic check_line(input string tag, input logic tx_exp, input logic busy_exp);
    assert_cnt++;
    assert (bus_if.TX_out === tx_exp) else begin
      fail_cnt++;
      $error("FAIL %s TX_out: observed %b expected %b", tag, bus_if.TX_out, tx_exp);
    end
    assert_cnt++;
    assert (bus_if.Busy === busy_exp) else begin
      fail_cnt++;
      $error("FAIL %s Busy: observed %b expected %b", tag, bus_if.Busy, busy_exp);
    end
  endtask

  task automatic check_one(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      assert_cnt++;
      fail_cnt++;
      $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_line(tag, e[1], e[0]);
    end
  endtask

  // Raise Data_Valid for one rising edge (caller is at a falling edge)
  task automatic start_frame(input logic [DATA_WD-1:0] d, input logic pen, input logic ptyp);
    @(negedge Clk);
    bus_if.P_Data     = d;
    bus_if.Parity_En  = pen;
    bus_if.Parity_Typ = ptyp;
    bus_if.Data_Valid = 1'b1;
    push_frame(d, pen, ptyp);
  endtask

  // Send one frame and check every cycle until two idle cycles after it.
  // With inject set, a 0x55 request plus flipped parity settings is presented
  // mid-DATA and again during the stop cycle; both must be ignored.
  task automatic run_frame(input string name, input logic [DATA_WD-1:0] d,
                           input logic pen, input logic ptyp, input logic inject);
    int len;
    len = DATA_WD + 2 + (pen ? 1 : 0);
    start_frame(d, pen, ptyp);
    for (int k = 0; k < len + 2; k++) begin
      @(negedge Clk);
      bus_if.Data_Valid = 1'b0;
      check_one($sformatf("%s[%0d]", name, k));
      if (inject && (k == 3 || k == len - 1)) begin
        bus_if.Data_Valid = 1'b1;
        bus_if.P_Data     = 8'h55;
        bus_if.Parity_En  = ~pen;
        bus_if.Parity_Typ = ~ptyp;
      end
    end
    $display("frame %s data=%h pen=%b ptyp=%b done", name, d, pen, ptyp);
  endtask

  initial begin
    Rst               = 1'b0;
    bus_if.P_Data     = '0;
    bus_if.Data_Valid = 1'b0;
    bus_if.Parity_En  = 1'b0;
    bus_if.Parity_Typ = 1'b0;

    #12;
    check_line("reset", 1'b1, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check_line("idle_after_reset", 1'b1, 1'b0);

    run_frame("np_A3",   8'hA3, 1'b0, 1'b0, 1'b0);
    run_frame("np_B4",   8'hB4, 1'b0, 1'b0, 1'b0);
    run_frame("odd_D2",  8'hD2, 1'b1, 1'b1, 1'b0);
    run_frame("even_D2", 8'hD2, 1'b1, 1'b0, 1'b0);
    run_frame("even_07", 8'h07, 1'b1, 1'b0, 1'b0);
    run_frame("prot_np", 8'hA3, 1'b0, 1'b0, 1'b1);
    run_frame("prot_odd",8'h3C, 1'b1, 1'b1, 1'b1);

    // Reset mid-frame during DATA: outputs must go idle without a clock edge
    start_frame(8'hA3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      bus_if.Data_Valid = 1'b0;
      check_one($sformatf("pre_rst[%0d]", k));
    end
    #2 Rst = 1'b0;
    #1 check_line("async_rst", 1'b1, 1'b0);
    exp_q.delete();
    @(negedge Clk);
    check_line("held_rst", 1'b1, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);
    check_line("after_rst", 1'b1, 1'b0);
    $display("reset mid-frame done");

    run_frame("post_rst_A3", 8'hA3, 1'b0, 1'b0, 1'b0);

    assert_cnt++;
    assert (exp_q.size() == 0) else begin
      fail_cnt++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
